// File: rtl/icb_pkg.sv
// icb_pkg: shared types and default parameters for the ICB round-robin mux slice
//   arb_state_e : arbiter FSM states
//   icb_cmd_t   : one ICB command beat (addr, read, wdata, wmask) at default widths
package icb_pkg;
    localparam int ICB_AW       = 32;
    localparam int ICB_DW       = 32;
    localparam int OUTS_MAX_DEF = 4;
    localparam int QUANTUM_DEF  = 16;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_e;

    typedef struct packed {
        logic [ICB_AW-1:0]   addr;
        logic                read;
        logic [ICB_DW-1:0]   wdata;
        logic [ICB_DW/8-1:0] wmask;
    } icb_cmd_t;
endpackage

// File: rtl/icb_rr_mux_rr_pick.sv
// rr_pick: combinational round-robin picker
//   req : request vector
//   ptr : highest-priority index (must be < N)
//   gnt : one-hot grant of the first requester at or after ptr, wrapping
//   idx : index of the granted requester
//   any : at least one request present
module rr_pick #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    // Scan from farthest to nearest so the requester closest to ptr is written last and wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
    end

    assign any = |req;
    assign gnt = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/icb_rr_mux.sv
// icb_rr_mux: round-robin arbiter sharing one ICB master port between N_M clients
//   clk, rst_n                      : clock, asynchronous active-low reset
//   m_cmd_* (valid/ready/addr/read/wdata/wmask) : per-client command channels (flattened)
//   m_rsp_* (valid/ready, shared rdata/err)     : per-client response channels
//   s_cmd_*, s_rsp_*                : single command/response port toward memory
//   owner                           : current owner index
//   busy                            : arbiter not idle
//   err_spurious                    : sticky, response arrived with nothing outstanding
module icb_rr_mux
    import icb_pkg::*;
#(
    parameter int N_M      = 5,
    parameter int AW       = ICB_AW,
    parameter int DW       = ICB_DW,
    parameter int OUTS_MAX = OUTS_MAX_DEF,
    parameter int QUANTUM  = QUANTUM_DEF,
    localparam int OW      = (N_M > 1) ? $clog2(N_M) : 1,
    localparam int CW      = $clog2(OUTS_MAX + 1),
    localparam int QW      = $clog2(QUANTUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_M-1:0]        m_cmd_valid,
    output logic [N_M-1:0]        m_cmd_ready,
    input  logic [N_M*AW-1:0]     m_cmd_addr,
    input  logic [N_M-1:0]        m_cmd_read,
    input  logic [N_M*DW-1:0]     m_cmd_wdata,
    input  logic [N_M*DW/8-1:0]   m_cmd_wmask,
    output logic [N_M-1:0]        m_rsp_valid,
    input  logic [N_M-1:0]        m_rsp_ready,
    output logic [DW-1:0]         m_rsp_rdata,
    output logic                  m_rsp_err,
    output logic                  s_cmd_valid,
    input  logic                  s_cmd_ready,
    output logic [AW-1:0]         s_cmd_addr,
    output logic                  s_cmd_read,
    output logic [DW-1:0]         s_cmd_wdata,
    output logic [DW/8-1:0]       s_cmd_wmask,
    input  logic                  s_rsp_valid,
    output logic                  s_rsp_ready,
    input  logic [DW-1:0]         s_rsp_rdata,
    input  logic                  s_rsp_err,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic                  err_spurious
);
    arb_state_e     state, state_nxt;
    logic [OW-1:0]  rr_ptr, pick_idx;
    logic [N_M-1:0] own_oh, pick_oh;
    logic [CW-1:0]  outs, outs_nxt;
    logic [QW-1:0]  beat_cnt, beat_nxt;
    logic           pick_any, own_valid, others, room, spur, cmd_hs, rsp_hs;

    rr_pick #(.N(N_M), .IW(OW)) u_pick (
        .req (m_cmd_valid),
        .ptr (rr_ptr),
        .gnt (pick_oh),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign own_valid = |(m_cmd_valid & own_oh);
    assign others    = |(m_cmd_valid & ~own_oh);
    assign room      = outs < CW'(OUTS_MAX);
    // A response with nothing outstanding is swallowed here and never reaches a client.
    assign spur      = s_rsp_valid && outs == '0;
    assign cmd_hs    = s_cmd_valid && s_cmd_ready;
    assign rsp_hs    = s_rsp_valid && s_rsp_ready && !spur;
    assign outs_nxt  = outs + CW'(cmd_hs) - CW'(rsp_hs);
    assign beat_nxt  = (cmd_hs && beat_cnt != QW'(QUANTUM)) ? beat_cnt + QW'(1) : beat_cnt;

    assign s_cmd_addr  = m_cmd_addr[owner*AW +: AW];
    assign s_cmd_read  = m_cmd_read[owner];
    assign s_cmd_wdata = m_cmd_wdata[owner*DW +: DW];
    assign s_cmd_wmask = m_cmd_wmask[owner*(DW/8) +: DW/8];
    assign m_rsp_rdata = s_rsp_rdata;
    assign m_rsp_err   = s_rsp_err;
    assign busy        = state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // Quantum expiry uses the saturated count including this cycle's handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pick_any ? GRANT : IDLE;
            GRANT:   state_nxt = (!own_valid || (beat_nxt == QW'(QUANTUM) && others)) ? DRAIN : GRANT;
            DRAIN:   state_nxt = (outs_nxt == '0) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_cmd_valid = state == GRANT && own_valid && room;
        m_cmd_ready = (state == GRANT && room && s_cmd_ready) ? own_oh : '0;
        s_rsp_ready = (outs == '0) ? s_rsp_valid : |(m_rsp_ready & own_oh);
        m_rsp_valid = (s_rsp_valid && !spur) ? own_oh : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= '0;
            own_oh       <= N_M'(1);
            rr_ptr       <= '0;
            outs         <= '0;
            beat_cnt     <= '0;
            err_spurious <= 1'b0;
        end else begin
            outs         <= outs_nxt;
            err_spurious <= err_spurious || spur;
            if (state == IDLE && pick_any) begin
                owner    <= pick_idx;
                own_oh   <= pick_oh;
                beat_cnt <= '0;
            end else if (state == GRANT) begin
                beat_cnt <= beat_nxt;
            end
            if (state == DRAIN && state_nxt == IDLE)
                rr_ptr <= (owner == OW'(N_M - 1)) ? '0 : owner + OW'(1);
        end
    end
endmodule

// File: tb/tb_icb_rr_mux.sv
// tb_icb_rr_mux: directed self-checking bench for icb_rr_mux
module tb_icb_rr_mux;
    import icb_pkg::*;
    localparam int N_M = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_M-1:0]      m_cmd_valid, m_cmd_ready, m_cmd_read, m_rsp_valid, m_rsp_ready;
    logic [N_M*AW-1:0]   m_cmd_addr;
    logic [N_M*DW-1:0]   m_cmd_wdata;
    logic [N_M*DW/8-1:0] m_cmd_wmask;
    logic [DW-1:0]       m_rsp_rdata, s_cmd_wdata, s_rsp_rdata;
    logic                m_rsp_err, s_cmd_valid, s_cmd_ready, s_cmd_read;
    logic [AW-1:0]       s_cmd_addr;
    logic [DW/8-1:0]     s_cmd_wmask;
    logic                s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [2:0]          owner;
    logic                busy, err_spurious;
    int                  checks = 0;
    int                  failures = 0;
    icb_cmd_t            vec [4];

    icb_rr_mux #(.N_M(N_M), .AW(AW), .DW(DW), .OUTS_MAX(4), .QUANTUM(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err(m_rsp_err),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
        .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err(s_rsp_err),
        .owner(owner), .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input icb_cmd_t c);
        m_cmd_addr[i*AW +: AW]          = c.addr;
        m_cmd_read[i]                   = c.read;
        m_cmd_wdata[i*DW +: DW]         = c.wdata;
        m_cmd_wmask[i*(DW/8) +: DW/8]   = c.wmask;
    endtask

    task automatic clear_inputs;
        m_cmd_valid = '0; m_cmd_read = '0; m_cmd_addr = '0; m_cmd_wdata = '0; m_cmd_wmask = '0;
        m_rsp_ready = '0; s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_rdata = '0; s_rsp_err = 1'b0;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // One owner: a single command, its response while valid drops, then drain and idle.
    task automatic serve(input int exp_own, input logic [N_M-1:0] vld_after);
        chk("rr_owner", owner, exp_own);
        chk("rr_ready", m_cmd_ready, N_M'(1) << exp_own);
        tick();
        m_cmd_valid = vld_after;
        s_rsp_valid = 1'b1;
        #1;
        chk("rr_rspv", m_rsp_valid, N_M'(1) << exp_own);
        tick();
        s_rsp_valid = 1'b0;
        #1;
        chk("rr_drain_busy", busy, 1);
        chk("rr_drain_svalid", s_cmd_valid, 0);
        tick();
        chk("rr_idle_busy", busy, 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec[0] = '{addr: 32'h0000_0100, read: 1'b0, wdata: 32'hA5A5_0001, wmask: 4'hF};
        vec[1] = '{addr: 32'h0000_0104, read: 1'b0, wdata: 32'h5A5A_0002, wmask: 4'h3};
        vec[2] = '{addr: 32'h0000_0108, read: 1'b1, wdata: 32'h0,         wmask: 4'h0};
        vec[3] = '{addr: 32'h0000_010C, read: 1'b1, wdata: 32'h0,         wmask: 4'h0};

        // Reset values
        clear_inputs();
        rst_n = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mready", m_cmd_ready, 0);
        chk("rst_mrspv", m_rsp_valid, 0);
        chk("rst_svalid", s_cmd_valid, 0);
        chk("rst_srready", s_rsp_ready, 0);
        chk("rst_err", err_spurious, 0);
        rst_n = 1'b1;
        #1;

        // Single client 2: two writes then two reads, responses one cycle behind
        set_cmd(2, vec[0]);
        m_cmd_valid = 5'b00100;
        m_rsp_ready = 5'b00100;
        s_cmd_ready = 1'b1;
        #1;
        chk("idle_no_pass", m_cmd_ready, 0);
        chk("idle_svalid", s_cmd_valid, 0);
        tick();
        chk("t1_owner", owner, 2);
        chk("t1_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            set_cmd(2, vec[k]);
            s_rsp_valid = k > 0;
            s_rsp_rdata = 32'hD000_0000 + k;
            #1;
            chk("t1_ready", m_cmd_ready, 5'b00100);
            chk("t1_addr", s_cmd_addr, vec[k].addr);
            chk("t1_read", s_cmd_read, vec[k].read);
            chk("t1_wdata", s_cmd_wdata, vec[k].wdata);
            chk("t1_wmask", s_cmd_wmask, vec[k].wmask);
            chk("t1_rspv", m_rsp_valid, (k > 0) ? 5'b00100 : 5'b00000);
            tick();
        end
        m_cmd_valid = '0;
        s_rsp_valid = 1'b1;
        s_rsp_rdata = 32'hCAFE_0004;
        s_rsp_err   = 1'b1;
        #1;
        chk("t1_last_rspv", m_rsp_valid, 5'b00100);
        chk("t1_last_rdata", m_rsp_rdata, 32'hCAFE_0004);
        chk("t1_last_err", m_rsp_err, 1);
        chk("t1_last_srready", s_rsp_ready, 1);
        chk("t1_drop_svalid", s_cmd_valid, 0);
        tick();
        s_rsp_valid = 1'b0;
        s_rsp_err   = 1'b0;
        #1;
        chk("t1_drain_busy", busy, 1);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_no_spur", err_spurious, 0);

        // Clients 0,2,4 together from reset: served 0, 2, 4
        reset_dut();
        m_rsp_ready = '1;
        s_cmd_ready = 1'b1;
        m_cmd_valid = 5'b10101;
        #1;
        tick();
        serve(0, 5'b10100);
        serve(2, 5'b10000);
        serve(4, 5'b00000);
        chk("rr_end_idle", busy, 0);

        // Quantum: client 1 streams, client 3 waits from the start
        reset_dut();
        m_rsp_ready = '1;
        s_cmd_ready = 1'b1;
        m_cmd_valid = 5'b01010;
        #1;
        tick();
        chk("q_owner", owner, 1);
        tick();
        s_rsp_valid = 1'b1;
        #1;
        for (int k = 2; k <= 16; k++) begin
            chk("q_ready", m_cmd_ready, 5'b00010);
            tick();
        end
        chk("q_after16_ready", m_cmd_ready, 0);
        chk("q_after16_busy", busy, 1);
        tick();
        s_rsp_valid = 1'b0;
        #1;
        chk("q_idle", busy, 0);
        tick();
        chk("q_next_owner", owner, 3);
        chk("q_next_ready", m_cmd_ready, 5'b01000);

        // Quantum ignored while alone, then expires at once when a rival appears
        reset_dut();
        m_rsp_ready = '1;
        s_cmd_ready = 1'b1;
        m_cmd_valid = 5'b00010;
        #1;
        tick();
        tick();
        s_rsp_valid = 1'b1;
        #1;
        for (int k = 2; k <= 20; k++) begin
            chk("sat_ready", m_cmd_ready, 5'b00010);
            tick();
        end
        m_cmd_valid = 5'b01010;
        #1;
        chk("sat_last_ready", m_cmd_ready, 5'b00010);
        tick();
        chk("sat_drain_ready", m_cmd_ready, 0);
        chk("sat_drain_busy", busy, 1);
        tick();
        s_rsp_valid = 1'b0;
        #1;
        chk("sat_idle", busy, 0);
        tick();
        chk("sat_next_owner", owner, 3);

        // Response stall: four accepted, fifth held until a response handshake
        reset_dut();
        m_rsp_ready = '1;
        s_cmd_ready = 1'b1;
        m_cmd_valid = 5'b00001;
        #1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("st_ready", m_cmd_ready, 5'b00001);
            tick();
        end
        chk("st_full_ready", m_cmd_ready, 0);
        chk("st_full_svalid", s_cmd_valid, 0);
        tick();
        chk("st_hold", m_cmd_ready, 0);
        s_rsp_valid = 1'b1;
        #1;
        chk("st_rsp_ready", s_rsp_ready, 1);
        chk("st_hold_rsp", m_cmd_ready, 0);
        tick();
        s_rsp_valid = 1'b0;
        #1;
        chk("st_resume", m_cmd_ready, 5'b00001);

        // Simultaneous cmd+rsp at outs=2 keeps 2; then spurious response
        reset_dut();
        m_rsp_ready = '1;
        s_cmd_ready = 1'b1;
        m_cmd_valid = 5'b00001;
        #1;
        tick();
        tick();
        tick();
        s_rsp_valid = 1'b1;
        #1;
        chk("sim_cmd", m_cmd_ready, 5'b00001);
        chk("sim_rsp", s_rsp_ready, 1);
        tick();
        s_rsp_valid = 1'b0;
        #1;
        chk("sim_room3", m_cmd_ready, 5'b00001);
        tick();
        chk("sim_room4", m_cmd_ready, 5'b00001);
        tick();
        chk("sim_full", m_cmd_ready, 0);
        m_cmd_valid = '0;
        s_rsp_valid = 1'b1;
        #1;
        tick();
        tick();
        tick();
        chk("sim_drain", busy, 1);
        tick();
        chk("sim_idle", busy, 0);
        chk("spur_ready", s_rsp_ready, 1);
        chk("spur_fwd", m_rsp_valid, 0);
        chk("spur_pre", err_spurious, 0);
        tick();
        chk("spur_set", err_spurious, 1);
        s_rsp_valid = 1'b0;
        tick();
        chk("spur_sticky", err_spurious, 1);

        // Asynchronous reset mid-GRANT with three outstanding
        m_cmd_valid = 5'b00001;
        #1;
        tick();
        chk("ar_owner", owner, 0);
        tick();
        tick();
        tick();
        chk("ar_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_owner0", owner, 0);
        chk("ar_mready", m_cmd_ready, 0);
        chk("ar_svalid", s_cmd_valid, 0);
        chk("ar_err", err_spurious, 0);
        chk("ar_mrspv", m_rsp_valid, 0);
        chk("ar_srready", s_rsp_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cmd_valid = '0;
        m_rsp_ready = '0;
        s_rsp_valid = 1'b1;
        #1;
        chk("ar_outs0_drop", s_rsp_ready, 1);
        chk("ar_outs0_fwd", m_rsp_valid, 0);
        chk("ar_idle", busy, 0);
        tick();
        s_rsp_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
